// File: rtl/antares_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : antares_muldiv_ctrl_pkg
// Description : Shared ALU operation codes, controller state encoding and
//               op-class decode helpers for the EX-stage mul/div sequencer.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package antares_muldiv_ctrl_pkg;

  // ALU operation codes (shared ALU_OP_* encoding, 5 bits)
  localparam logic [4:0] ALU_OP_NOP   = 5'd0;
  localparam logic [4:0] ALU_OP_MFHI  = 5'd16;
  localparam logic [4:0] ALU_OP_MFLO  = 5'd17;
  localparam logic [4:0] ALU_OP_MTHI  = 5'd18;
  localparam logic [4:0] ALU_OP_MTLO  = 5'd19;
  localparam logic [4:0] ALU_OP_MULS  = 5'd20;
  localparam logic [4:0] ALU_OP_MULU  = 5'd21;
  localparam logic [4:0] ALU_OP_DIV   = 5'd22;
  localparam logic [4:0] ALU_OP_DIVU  = 5'd23;
  localparam logic [4:0] ALU_OP_MADD  = 5'd24;
  localparam logic [4:0] ALU_OP_MADDU = 5'd25;
  localparam logic [4:0] ALU_OP_MSUB  = 5'd26;
  localparam logic [4:0] ALU_OP_MSUBU = 5'd27;

  // Controller state encoding
  typedef enum logic [1:0] {
    MDC_IDLE = 2'd0,
    MDC_MUL  = 2'd1,
    MDC_DIV  = 2'd2
  } mdc_state_e;

  // Op-class decode
  function automatic logic is_mul_class(input logic [4:0] o);
    return (o == ALU_OP_MULS)  || (o == ALU_OP_MULU)  ||
           (o == ALU_OP_MADD)  || (o == ALU_OP_MADDU) ||
           (o == ALU_OP_MSUB)  || (o == ALU_OP_MSUBU);
  endfunction

  function automatic logic is_div_class(input logic [4:0] o);
    return (o == ALU_OP_DIV) || (o == ALU_OP_DIVU);
  endfunction

  function automatic logic mul_is_signed(input logic [4:0] o);
    return (o == ALU_OP_MULS) || (o == ALU_OP_MADD) || (o == ALU_OP_MSUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/antares_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : antares_muldiv_ctrl
// Description : Sequencing controller for the EX-stage multiplier and
//               divider. Owns the 64-bit HILO register, latches operands into
//               the selected unit, issues start/abort pulses, performs HILO
//               write-back (incl. MADD/MSUB accumulation) and requests stalls.
// Ports       : clk, rst (sync, active-high)
//               op/op_valid/port_a/port_b  - EX instruction and operands
//               ex_stall/ex_flush          - pipeline control from elsewhere
//               request_stall              - hold EX until HILO written
//               hi/lo                      - HILO register for MFHI/MFLO
//               mult_*                     - multiplier handshake/operands
//               div_*, quotient, remainder - divider handshake/operands
// Revision    : 1.0 - initial release
// ============================================================================
module antares_muldiv_ctrl
  import antares_muldiv_ctrl_pkg::*;
#(
  parameter bit ENABLE_HW_MULT = 1'b1,
  parameter bit ENABLE_HW_DIV  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  op,
  input  logic        op_valid,
  input  logic [31:0] port_a,
  input  logic [31:0] port_b,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic        request_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mult_start,
  output logic        mult_signed,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_abort,
  input  logic        mult_ready,
  input  logic [63:0] mult_result,
  output logic        div_start_s,
  output logic        div_start_u,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_abort,
  input  logic        div_done,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder
);

  mdc_state_e  state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [63:0] hilo_q, hilo_d;
  logic [31:0] mult_a_q, mult_a_d;
  logic [31:0] mult_b_q, mult_b_d;
  logic        mult_signed_q, mult_signed_d;
  logic        mult_start_q, mult_start_d;
  logic        mult_abort_q, mult_abort_d;
  logic        div_start_s_q, div_start_s_d;
  logic        div_start_u_q, div_start_u_d;
  logic [31:0] div_dividend_q, div_dividend_d;
  logic [31:0] div_divisor_q, div_divisor_d;
  logic        div_abort_q, div_abort_d;

  logic        mul_op;
  logic        div_op;
  logic        div_ok;
  logic        issue;
  logic        start_pending;
  logic [63:0] mul_wb;

  // A disabled unit makes its ops decode as plain no-ops.
  assign mul_op = ENABLE_HW_MULT && is_mul_class(op);
  assign div_op = ENABLE_HW_DIV && is_div_class(op);
  // Divide by zero never starts the divider and leaves HILO alone.
  assign div_ok = div_op && (port_b != 32'd0);

  assign issue = (state_q == MDC_IDLE) && op_valid && !ex_stall && !ex_flush;

  // Deliberately independent of ex_stall/ex_flush: the pipeline combines
  // request_stall into its own stall, so feeding that back would loop.
  assign start_pending = (state_q == MDC_IDLE) && op_valid && (mul_op || div_ok);
  assign request_stall = start_pending ||
                         ((state_q == MDC_MUL) && !mult_ready) ||
                         ((state_q == MDC_DIV) && !div_done);

  // Write-back value for the latched multiply-class op (modulo 2^64).
  always_comb begin
    mul_wb = mult_result;
    case (op_q)
      ALU_OP_MADD, ALU_OP_MADDU: mul_wb = hilo_q + mult_result;
      ALU_OP_MSUB, ALU_OP_MSUBU: mul_wb = hilo_q - mult_result;
      default:                   mul_wb = mult_result;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    hilo_d         = hilo_q;
    mult_a_d       = mult_a_q;
    mult_b_d       = mult_b_q;
    mult_signed_d  = mult_signed_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    mult_start_d   = 1'b0;
    mult_abort_d   = 1'b0;
    div_start_s_d  = 1'b0;
    div_start_u_d  = 1'b0;
    div_abort_d    = 1'b0;

    case (state_q)
      MDC_IDLE: begin
        // Stray ready/done pulses are simply not looked at here.
        if (issue) begin
          if (mul_op) begin
            mult_start_d  = 1'b1;
            mult_a_d      = port_a;
            mult_b_d      = port_b;
            mult_signed_d = mul_is_signed(op);
            op_d          = op;
            state_d       = MDC_MUL;
          end else if (div_ok) begin
            div_start_s_d  = (op == ALU_OP_DIV);
            div_start_u_d  = (op == ALU_OP_DIVU);
            div_dividend_d = port_a;
            div_divisor_d  = port_b;
            op_d           = op;
            state_d        = MDC_DIV;
          end else if (op == ALU_OP_MTHI) begin
            hilo_d[63:32] = port_a;
          end else if (op == ALU_OP_MTLO) begin
            hilo_d[31:0] = port_a;
          end
        end
      end

      MDC_MUL: begin
        // Flush beats a coincident ready: result dropped, no abort needed
        // since the unit has already finished.
        if (ex_flush) begin
          mult_abort_d = !mult_ready;
          state_d      = MDC_IDLE;
        end else if (mult_ready) begin
          hilo_d  = mul_wb;
          state_d = MDC_IDLE;
        end
      end

      MDC_DIV: begin
        if (ex_flush) begin
          div_abort_d = !div_done;
          state_d     = MDC_IDLE;
        end else if (div_done) begin
          hilo_d  = {remainder, quotient};
          state_d = MDC_IDLE;
        end
      end

      default: state_d = MDC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= MDC_IDLE;
      op_q           <= ALU_OP_NOP;
      hilo_q         <= 64'd0;
      mult_a_q       <= 32'd0;
      mult_b_q       <= 32'd0;
      mult_signed_q  <= 1'b0;
      mult_start_q   <= 1'b0;
      mult_abort_q   <= 1'b0;
      div_start_s_q  <= 1'b0;
      div_start_u_q  <= 1'b0;
      div_dividend_q <= 32'd0;
      div_divisor_q  <= 32'd0;
      div_abort_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      hilo_q         <= hilo_d;
      mult_a_q       <= mult_a_d;
      mult_b_q       <= mult_b_d;
      mult_signed_q  <= mult_signed_d;
      mult_start_q   <= mult_start_d;
      mult_abort_q   <= mult_abort_d;
      div_start_s_q  <= div_start_s_d;
      div_start_u_q  <= div_start_u_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      div_abort_q    <= div_abort_d;
    end
  end

  assign hi           = hilo_q[63:32];
  assign lo           = hilo_q[31:0];
  assign mult_start   = mult_start_q;
  assign mult_signed  = mult_signed_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign mult_abort   = mult_abort_q;
  assign div_start_s  = div_start_s_q;
  assign div_start_u  = div_start_u_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;
  assign div_abort    = div_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_antares_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_antares_muldiv_ctrl
// Description : Self-checking bench for antares_muldiv_ctrl with behavioural
//               multiplier/divider responders and a HILO scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_antares_muldiv_ctrl;
  import antares_muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  op;
  logic        op_valid;
  logic [31:0] port_a, port_b;
  logic        ex_stall, ex_flush;
  logic        request_stall;
  logic [31:0] hi, lo;
  logic        mult_start, mult_signed, mult_abort, mult_ready;
  logic [31:0] mult_a, mult_b;
  logic [63:0] mult_result;
  logic        div_start_s, div_start_u, div_abort, div_done;
  logic [31:0] div_dividend, div_divisor, quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_hilo;

  antares_muldiv_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid),
    .port_a(port_a), .port_b(port_b), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .request_stall(request_stall), .hi(hi), .lo(lo),
    .mult_start(mult_start), .mult_signed(mult_signed), .mult_a(mult_a),
    .mult_b(mult_b), .mult_abort(mult_abort), .mult_ready(mult_ready),
    .mult_result(mult_result), .div_start_s(div_start_s),
    .div_start_u(div_start_u), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_abort(div_abort), .div_done(div_done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural multiplier: 64-bit product of the operands the bench drove.
  function automatic logic [63:0] mul_model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic [63:0] xa, xb;
    sgn = (o == ALU_OP_MULS) || (o == ALU_OP_MADD) || (o == ALU_OP_MSUB);
    xa  = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    xb  = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return xa * xb;
  endfunction

  // Behavioural divider: {remainder, quotient}.
  function automatic logic [63:0] div_model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (o == ALU_OP_DIV) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Drives one mul/div instruction from issue to write-back, acting as the
  // functional unit (ready/done lat cycles after the start pulse).
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, output int stall_cnt, output int start_cnt,
                        output logic [2:0] seen, output bit stall_at_done, output bit timed_out);
    int guard;
    bit is_div;
    logic [63:0] r;
    op = o; port_a = a; port_b = b; op_valid = 1'b1;
    #1;
    stall_cnt = 0; start_cnt = 0; seen = 3'b000; stall_at_done = 1'b0; timed_out = 1'b0; guard = 0;
    while (!(mult_start || div_start_s || div_start_u) && guard < 8) begin
      if (request_stall) stall_cnt++;
      step();
      guard++;
    end
    if (guard == 8) begin
      timed_out = 1'b1;
      op_valid  = 1'b0;
      return;
    end
    is_div = div_start_s || div_start_u;
    for (int i = 0; i < lat; i++) begin
      if (request_stall) stall_cnt++;
      if (mult_start || div_start_s || div_start_u) start_cnt++;
      seen = seen | {mult_start, div_start_s, div_start_u};
      step();
    end
    if (is_div) begin
      r = div_model(o, a, b);
      div_done = 1'b1; quotient = r[31:0]; remainder = r[63:32];
    end else begin
      mult_ready = 1'b1; mult_result = mul_model(o, a, b);
    end
    #1;
    stall_at_done = request_stall;
    step();
    mult_ready = 1'b0; div_done = 1'b0; op_valid = 1'b0; op = ALU_OP_NOP;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h expected %h", {hi, lo}, 64'd0); end
    n_checks++;
    if ({request_stall, mult_start, mult_abort, div_start_s, div_start_u, div_abort} !== 6'd0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected %b",
        {request_stall, mult_start, mult_abort, div_start_s, div_start_u, div_abort}, 6'd0);
    end
    n_checks++;
    if ({mult_a, mult_b, div_dividend, div_divisor} !== 128'd0) begin
      n_fail++; $display("FAIL reset_operands: got %h expected 0", {mult_a, mult_b, div_dividend, div_divisor});
    end
    model_hilo = 64'd0;
  endtask

  task automatic test_mulu();
    int sc, stc; logic [2:0] seen; bit sad, to;
    logic [63:0] e;
    model_hilo = 64'h00000001_FFFFFFFE;
    exp_q.push_back(model_hilo);
    run_op(ALU_OP_MULU, 32'hFFFFFFFF, 32'd2, 4, sc, stc, seen, sad, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL mulu_timeout: start seen 0 expected 1"); end
    n_checks++;
    if (sc !== 5) begin n_fail++; $display("FAIL mulu_stall_cycles: got %0d expected 5", sc); end
    n_checks++;
    if (seen !== 3'b100 || stc !== 1) begin n_fail++; $display("FAIL mulu_start: got %b/%0d expected 100/1", seen, stc); end
    n_checks++;
    if (sad !== 1'b0) begin n_fail++; $display("FAIL mulu_stall_at_ready: got %b expected 0", sad); end
    n_checks++;
    if ({mult_a, mult_b, mult_signed} !== {32'hFFFFFFFF, 32'd2, 1'b0}) begin
      n_fail++; $display("FAIL mulu_operands: got %h %h %b expected ffffffff 00000002 0", mult_a, mult_b, mult_signed);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({hi, lo} !== e) begin n_fail++; $display("FAIL mulu_hilo: got %h expected %h", {hi, lo}, e); end
    op = ALU_OP_MFLO; op_valid = 1'b1;
    #1;
    n_checks++;
    if (lo !== 32'hFFFFFFFE || request_stall !== 1'b0) begin
      n_fail++; $display("FAIL mflo_read: got %h stall %b expected fffffffe stall 0", lo, request_stall);
    end
    step();
    op_valid = 1'b0; op = ALU_OP_NOP;
  endtask

  task automatic test_madd_msub();
    int sc, stc; logic [2:0] seen; bit sad, to;
    logic [63:0] e;
    op = ALU_OP_MTHI; port_a = 32'd5; op_valid = 1'b1;
    #1;
    n_checks++;
    if (request_stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b expected 0", request_stall); end
    step();
    n_checks++;
    if (hi !== 32'd5) begin n_fail++; $display("FAIL mthi_hi: got %h expected 00000005", hi); end
    op = ALU_OP_MTLO; port_a = 32'd7;
    step();
    op_valid = 1'b0;
    n_checks++;
    if ({hi, lo} !== 64'h00000005_00000007) begin n_fail++; $display("FAIL mtlo_hilo: got %h expected 0000000500000007", {hi, lo}); end

    model_hilo = 64'h00000005_00000004;
    exp_q.push_back(model_hilo);
    run_op(ALU_OP_MADD, 32'hFFFFFFFF, 32'd3, 3, sc, stc, seen, sad, to);
    n_checks++;
    if (to || mult_signed !== 1'b1) begin n_fail++; $display("FAIL madd_start: timeout %b signed %b expected 0/1", to, mult_signed); end
    e = exp_q.pop_front();
    n_checks++;
    if ({hi, lo} !== e) begin n_fail++; $display("FAIL madd_hilo: got %h expected %h", {hi, lo}, e); end

    model_hilo = 64'h00000005_00000007;
    exp_q.push_back(model_hilo);
    run_op(ALU_OP_MSUB, 32'hFFFFFFFF, 32'd3, 2, sc, stc, seen, sad, to);
    n_checks++;
    if (to || sc !== 3) begin n_fail++; $display("FAIL msub_stall: timeout %b cycles %0d expected 0/3", to, sc); end
    e = exp_q.pop_front();
    n_checks++;
    if ({hi, lo} !== e) begin n_fail++; $display("FAIL msub_hilo: got %h expected %h", {hi, lo}, e); end
  endtask

  task automatic test_div();
    int sc, stc; logic [2:0] seen; bit sad, to;
    logic [63:0] e;
    model_hilo = 64'hFFFFFFFF_FFFFFFFD;
    exp_q.push_back(model_hilo);
    run_op(ALU_OP_DIV, 32'hFFFFFFF9, 32'd2, 33, sc, stc, seen, sad, to);
    n_checks++;
    if (to || seen !== 3'b010 || stc !== 1) begin n_fail++; $display("FAIL div_start: timeout %b seen %b count %0d expected 0/010/1", to, seen, stc); end
    n_checks++;
    if (sc !== 34 || sad !== 1'b0) begin n_fail++; $display("FAIL div_stall: cycles %0d at_done %b expected 34/0", sc, sad); end
    n_checks++;
    if ({div_dividend, div_divisor} !== {32'hFFFFFFF9, 32'd2}) begin
      n_fail++; $display("FAIL div_operands: got %h %h expected fffffff9 00000002", div_dividend, div_divisor);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({hi, lo} !== e) begin n_fail++; $display("FAIL div_hilo: got %h expected %h", {hi, lo}, e); end
  endtask

  task automatic test_div_zero();
    bit any_start, any_stall;
    op = ALU_OP_DIVU; port_a = 32'd9; port_b = 32'd0; op_valid = 1'b1;
    #1;
    any_start = 1'b0; any_stall = request_stall;
    for (int i = 0; i < 4; i++) begin
      step();
      any_start = any_start | div_start_u | div_start_s;
      any_stall = any_stall | request_stall;
    end
    op_valid = 1'b0; op = ALU_OP_NOP;
    n_checks++;
    if (any_start || any_stall) begin n_fail++; $display("FAIL divu_zero: start %b stall %b expected 0/0", any_start, any_stall); end
    n_checks++;
    if ({hi, lo} !== model_hilo) begin n_fail++; $display("FAIL divu_zero_hilo: got %h expected %h", {hi, lo}, model_hilo); end
  endtask

  task automatic test_flush();
    int aborts;
    op = ALU_OP_DIV; port_a = 32'd100; port_b = 32'd7; op_valid = 1'b1;
    step();
    n_checks++;
    if (div_start_s !== 1'b1) begin n_fail++; $display("FAIL flush_div_start: got %b expected 1", div_start_s); end
    for (int i = 0; i < 9; i++) step();
    ex_flush = 1'b1;
    #1;
    n_checks++;
    if (request_stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall_indep: got %b expected 1", request_stall); end
    step();
    ex_flush = 1'b0; op_valid = 1'b0; op = ALU_OP_NOP;
    #1;
    aborts = 0;
    n_checks++;
    if (div_abort !== 1'b1) begin n_fail++; $display("FAIL flush_div_abort: got %b expected 1", div_abort); end
    for (int i = 0; i < 3; i++) begin
      if (div_abort) aborts++;
      step();
    end
    n_checks++;
    if (aborts !== 1 || request_stall !== 1'b0) begin n_fail++; $display("FAIL flush_abort_once: aborts %0d stall %b expected 1/0", aborts, request_stall); end
    // stray done in IDLE
    div_done = 1'b1; quotient = 32'd123; remainder = 32'd456;
    #1;
    n_checks++;
    if (request_stall !== 1'b0) begin n_fail++; $display("FAIL stray_done_stall: got %b expected 0", request_stall); end
    step();
    div_done = 1'b0;
    n_checks++;
    if ({hi, lo} !== model_hilo) begin n_fail++; $display("FAIL stray_done_hilo: got %h expected %h", {hi, lo}, model_hilo); end

    // flush coincident with ready: no write, no abort
    op = ALU_OP_MULU; port_a = 32'd3; port_b = 32'd4; op_valid = 1'b1;
    step();
    step();
    mult_ready = 1'b1; mult_result = 64'd12; ex_flush = 1'b1;
    step();
    mult_ready = 1'b0; ex_flush = 1'b0; op_valid = 1'b0; op = ALU_OP_NOP;
    #1;
    n_checks++;
    if (mult_abort !== 1'b0 || request_stall !== 1'b0) begin n_fail++; $display("FAIL flush_with_ready: abort %b stall %b expected 0/0", mult_abort, request_stall); end
    n_checks++;
    if ({hi, lo} !== model_hilo) begin n_fail++; $display("FAIL flush_with_ready_hilo: got %h expected %h", {hi, lo}, model_hilo); end

    // flush in IDLE suppresses a MOVE; a clean one afterwards lands
    op = ALU_OP_MTLO; port_a = 32'h0000DEAD; op_valid = 1'b1; ex_flush = 1'b1;
    step();
    ex_flush = 1'b0;
    n_checks++;
    if (lo !== model_hilo[31:0]) begin n_fail++; $display("FAIL flush_mtlo: got %h expected %h", lo, model_hilo[31:0]); end
    port_a = 32'h0000BEEF;
    step();
    op_valid = 1'b0; op = ALU_OP_NOP;
    model_hilo[31:0] = 32'h0000BEEF;
    n_checks++;
    if ({hi, lo} !== model_hilo) begin n_fail++; $display("FAIL mtlo_after_flush: got %h expected %h", {hi, lo}, model_hilo); end
  endtask

  task automatic test_stall_rst();
    bit early_start, stall_low;
    op = ALU_OP_MULS; port_a = 32'd7; port_b = 32'hFFFFFFFE; op_valid = 1'b1; ex_stall = 1'b1;
    #1;
    early_start = 1'b0; stall_low = 1'b0;
    for (int i = 0; i < 3; i++) begin
      early_start = early_start | mult_start;
      stall_low   = stall_low | !request_stall;
      step();
    end
    ex_stall = 1'b0;
    #1;
    early_start = early_start | mult_start;
    stall_low   = stall_low | !request_stall;
    n_checks++;
    if (early_start || stall_low) begin n_fail++; $display("FAIL ex_stall_hold: early start %b stall dropped %b expected 0/0", early_start, stall_low); end
    step();
    n_checks++;
    if (mult_start !== 1'b1 || mult_signed !== 1'b1) begin n_fail++; $display("FAIL muls_start: start %b signed %b expected 1/1", mult_start, mult_signed); end
    step(); step();
    rst = 1'b1; op_valid = 1'b0; op = ALU_OP_NOP;
    step();
    rst = 1'b0;
    #1;
    model_hilo = 64'd0;
    n_checks++;
    if ({hi, lo} !== model_hilo || request_stall !== 1'b0 || mult_abort !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_mul: hilo %h stall %b abort %b expected 0/0/0", {hi, lo}, request_stall, mult_abort);
    end
    // a late ready after reset must not write
    mult_ready = 1'b1; mult_result = 64'hDEAD_BEEF_0000_0001;
    step();
    mult_ready = 1'b0;
    n_checks++;
    if ({hi, lo} !== model_hilo) begin n_fail++; $display("FAIL rst_late_ready: got %h expected %h", {hi, lo}, model_hilo); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op = ALU_OP_NOP; op_valid = 1'b0; port_a = '0; port_b = '0;
    ex_stall = 1'b0; ex_flush = 1'b0; mult_ready = 1'b0; mult_result = '0;
    div_done = 1'b0; quotient = '0; remainder = '0; model_hilo = '0;
    test_reset();
    test_mulu();
    test_madd_msub();
    test_div();
    test_div_zero();
    test_flush();
    test_stall_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
